// File: rtl/hist_eq_div_pkg.sv
// Shared types and sizing helpers for the histogram-equalisation divider array.
package hist_eq_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LOAD = 3'd2,
    ST_DIV  = 3'd3,
    ST_WR   = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  localparam int DEF_LANES  = 8;
  localparam int DEF_CDF_W  = 32;
  localparam int DEF_PIX_W  = 8;
  localparam int DEF_ADDR_W = 16;

  // Remainder/product width: wide enough that (c - cdf_min) * (2^PIX_W-1) never overflows.
  function automatic int ext_width(input int cdf_w, input int pix_w);
    return cdf_w + pix_w;
  endfunction

  function automatic int cnt_width(input int pix_w);
    return $clog2(pix_w) + 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int cdf_w);
    return lane * cdf_w;
  endfunction

endpackage

// File: rtl/hist_eq_div_if.sv
// Control and scratch-memory bus of the divider array.
interface hist_eq_div_if #(
  parameter int LANES  = 8,
  parameter int CDF_W  = 32,
  parameter int ADDR_W = 16
) ();
  logic                     start;
  logic [CDF_W-1:0]         cdf_min;
  logic [CDF_W-1:0]         cdf_total;
  logic [ADDR_W-1:0]        rd_base;
  logic [ADDR_W-1:0]        wr_base;
  logic [ADDR_W-1:0]        n_words;
  logic                     busy;
  logic                     done;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [LANES*CDF_W-1:0]   rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [LANES*CDF_W-1:0]   wr_data;

  modport slave (
    input  start, cdf_min, cdf_total, rd_base, wr_base, n_words, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, cdf_min, cdf_total, rd_base, wr_base, n_words, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/hist_eq_div_lane.sv
// One lane: restoring bit-serial divider producing PIX_W quotient bits MSB first.
module hist_eq_div_lane
  import hist_eq_div_pkg::*;
#(
  parameter int CDF_W = 32,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [CDF_W-1:0] i_cdf,
  input  logic [CDF_W-1:0] i_cdf_min,
  input  logic [CDF_W-1:0] i_cdf_total,
  output logic [PIX_W-1:0] o_quot_next
);

  localparam int EXT_W = ext_width(CDF_W, PIX_W);

  logic [CDF_W-1:0] w_c;
  logic [CDF_W-1:0] w_diff;
  logic [CDF_W-1:0] w_den;
  logic [EXT_W-1:0] w_diff_ext;
  logic [EXT_W-1:0] w_num;
  logic [EXT_W-1:0] w_den_sh;
  logic             w_zero;
  logic             w_fit;
  logic             w_bit;

  logic [EXT_W-1:0] r_rem;
  logic [EXT_W-1:0] r_den_sh;
  logic [PIX_W-2:0] r_quot;
  logic             r_zero;

  assign w_c        = (i_cdf > i_cdf_total) ? i_cdf_total : i_cdf;
  assign w_zero     = (i_cdf <= i_cdf_min) || (i_cdf_total <= i_cdf_min);
  assign w_diff     = w_c - i_cdf_min;
  assign w_den      = i_cdf_total - i_cdf_min;
  assign w_diff_ext = {{PIX_W{1'b0}}, w_diff};
  // x * (2^PIX_W - 1) as a shift and subtract
  assign w_num      = (w_diff_ext << PIX_W) - w_diff_ext;
  // Quotient fits in PIX_W bits, so start with the divisor aligned to the MSB quotient bit
  assign w_den_sh   = {{PIX_W{1'b0}}, w_den} << (PIX_W - 1);

  assign w_fit       = (r_rem >= r_den_sh);
  assign w_bit       = w_fit & ~r_zero;
  assign o_quot_next = {r_quot, w_bit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem    <= '0;
      r_den_sh <= '0;
      r_quot   <= '0;
      r_zero   <= 1'b0;
    end else if (i_load) begin
      r_rem    <= w_zero ? '0 : w_num;
      r_den_sh <= w_den_sh;
      r_quot   <= '0;
      r_zero   <= w_zero;
    end else if (i_step && !r_zero) begin
      if (w_fit) begin
        r_rem <= r_rem - r_den_sh;
      end
      r_den_sh <= r_den_sh >> 1;
      r_quot   <= o_quot_next[PIX_W-2:0];
    end
  end

endmodule

// File: rtl/hist_eq_div_array.sv
// Block controller: reads CDF words, divides all lanes in lockstep, writes grey levels back.
module hist_eq_div_array
  import hist_eq_div_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int CDF_W  = DEF_CDF_W,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  hist_eq_div_if.slave  bus
);

  localparam int CNT_W = cnt_width(PIX_W);

  state_t                 r_state;
  logic [CDF_W-1:0]       r_cdf_min;
  logic [CDF_W-1:0]       r_cdf_total;
  logic [ADDR_W-1:0]      r_rd_base;
  logic [ADDR_W-1:0]      r_wr_base;
  logic [ADDR_W-1:0]      r_n_words;
  logic [ADDR_W-1:0]      r_i;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_rd_en;
  logic                   r_wr_en;
  logic [ADDR_W-1:0]      r_rd_addr;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic [LANES*CDF_W-1:0] r_wr_data;

  logic                   w_load;
  logic                   w_step;
  logic [ADDR_W:0]        w_i_inc;
  logic [PIX_W-1:0]       w_q_next [LANES];
  logic [LANES*CDF_W-1:0] w_word;

  assign w_load  = (r_state == ST_LOAD);
  assign w_step  = (r_state == ST_DIV);
  assign w_i_inc = {1'b0, r_i} + (ADDR_W+1)'(1);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      hist_eq_div_lane #(
        .CDF_W (CDF_W),
        .PIX_W (PIX_W)
      ) u_lane (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_cdf       (bus.rd_data[gi*CDF_W +: CDF_W]),
        .i_cdf_min   (r_cdf_min),
        .i_cdf_total (r_cdf_total),
        .o_quot_next (w_q_next[gi])
      );
      assign w_word[gi*CDF_W +: CDF_W] = {{(CDF_W-PIX_W){1'b0}}, w_q_next[gi]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cdf_min   <= '0;
      r_cdf_total <= '0;
      r_rd_base   <= '0;
      r_wr_base   <= '0;
      r_n_words   <= '0;
      r_i         <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_cdf_min   <= bus.cdf_min;
            r_cdf_total <= bus.cdf_total;
            r_rd_base   <= bus.rd_base;
            r_wr_base   <= bus.wr_base;
            r_n_words   <= bus.n_words;
            r_i         <= '0;
            if (bus.n_words == '0) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state   <= ST_RD;
              r_busy    <= 1'b1;
              r_rd_en   <= 1'b1;
              r_rd_addr <= bus.rd_base;
            end
          end
        end
        ST_RD: begin
          r_rd_en <= 1'b0;
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_cnt   <= '0;
          r_state <= ST_DIV;
        end
        ST_DIV: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Final quotient bit is captured straight from the lanes' next-value path
          if (r_cnt == CNT_W'(PIX_W - 1)) begin
            r_state   <= ST_WR;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_wr_base + r_i;
            r_wr_data <= w_word;
          end
        end
        ST_WR: begin
          r_wr_en <= 1'b0;
          r_i     <= w_i_inc[ADDR_W-1:0];
          if (w_i_inc < {1'b0, r_n_words}) begin
            r_state   <= ST_RD;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_rd_base + w_i_inc[ADDR_W-1:0];
          end else begin
            r_state <= ST_FIN;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_rd_en <= 1'b0;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

endmodule

// File: doc/hist_eq_div_array.md
HIST_EQ_DIV_ARRAY -- requirements
Module: hist_eq_div_array

Interface
REQ-001 Parameter LANES, default 8, number of parallel division lanes per memory word.
REQ-002 Parameter CDF_W, default 32, width of one CDF value and of one memory lane slot.
REQ-003 Parameter PIX_W, default 8, output grey-level width; quotient range is 0..2^PIX_W-1.
REQ-004 Parameter ADDR_W, default 16, scratch-memory address width.
REQ-005 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1, sole clock; all logic is rising-edge.
REQ-007 Port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-008 Port start, input, 1, single-cycle request to process a block; sampled only in IDLE.
REQ-009 Port cdf_min, input, CDF_W, minimum non-zero CDF; captured on accepted start.
REQ-010 Port cdf_total, input, CDF_W, pixel count N; captured on accepted start.
REQ-011 Port rd_base, wr_base, input, ADDR_W each, first read and write word addresses; captured on accepted start.
REQ-012 Port n_words, input, ADDR_W, number of words to process; captured on accepted start.
REQ-013 Port rd_en / rd_addr, output, 1 / ADDR_W, read strobe and address; data returns exactly 1 cycle later.
REQ-014 Port rd_data, input, LANES*CDF_W, read word; lane k occupies bits [k*CDF_W +: CDF_W].
REQ-015 Port wr_en / wr_addr / wr_data, output, 1 / ADDR_W / LANES*CDF_W, write strobe, address and word; lane k quotient zero-extended into bits [k*CDF_W +: CDF_W].
REQ-016 Port busy, output, 1, high from the cycle after accepted start until done.
REQ-017 Port done, output, 1, one-cycle pulse when the block is complete.

Function
REQ-018 Per lane: g = floor(((c - cdf_min) * (2^PIX_W-1)) / (cdf_total - cdf_min)), with c = min(cdf_in, cdf_total).
REQ-019 If cdf_in <= cdf_min, the lane result is 0, with no division performed.
REQ-020 If cdf_total <= cdf_min (zero or negative divisor), every lane result is 0.
REQ-021 Division is restoring and bit-serial: one quotient bit per cycle, MSB first, PIX_W cycles; all lanes run in lockstep.
REQ-022 Intermediate products and remainders carry CDF_W+PIX_W bits; there is no overflow or truncation before the quotient.
REQ-023 The FSM has the states IDLE, RD, LOAD, DIV, WR and FIN.
REQ-024 IDLE: on start, capture the inputs; if n_words = 0 go to FIN, else go to RD.
REQ-025 RD: assert rd_en for one cycle with rd_addr = rd_base + i.
REQ-026 LOAD: capture rd_data into the lane dividers.
REQ-027 DIV: run for PIX_W cycles.
REQ-028 WR: assert wr_en for one cycle with wr_addr = wr_base + i, then increment i; go to RD if i < n_words, else go to FIN.
REQ-029 FIN: pulse done and deassert busy in the same cycle; return to IDLE.
REQ-030 Throughput is fixed at PIX_W+3 cycles per word; done follows the last wr_en by exactly 1 cycle.
REQ-031 Addresses wrap modulo 2^ADDR_W without error.
REQ-032 start while busy is ignored, including start in the FIN cycle; captured inputs never change mid-block.
REQ-033 rd_en and wr_en are never high in the same cycle.

Reset
REQ-034 While reset = 0, the FSM is IDLE, i = 0, and every output is 0: busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data.
REQ-035 Reset asserted mid-block aborts immediately with no further memory strobes; deassertion leaves the block IDLE awaiting start.

Structure
REQ-036 A shared package holds the FSM state enum and the lane-slice width helper constants.
REQ-037 The per-lane bit-serial divider is the sub-module hist_eq_div_lane, instantiated LANES times by generate.
REQ-038 Control FSM, address counters and the write-word packing live in hist_eq_div_array.

Verification (LANES=4, CDF_W=32, PIX_W=8)
REQ-039 cdf_min=24, total=1024, lanes {524,1024,10,2000}, n_words=1 -> one write of lanes {127,255,0,255}; done 11 cycles after rd_en.
REQ-040 cdf_min=5, total=5, any lanes -> all lanes 0; one write per word.
REQ-041 n_words=0 -> done pulses 1 cycle after start; no rd_en or wr_en.
REQ-042 rd_base=0xFFFF, wr_base=0xFFFE, n_words=3 -> reads at FFFF,0000,0001 and writes at FFFE,FFFF,0000.
REQ-043 Reset pulled low during the DIV of word 2 of 4 -> outputs zero immediately; no wr_en afterwards; a new start runs a full correct block.
REQ-044 start re-asserted while busy with different parameters -> ignored; results match the first parameters.
